// File: rtl/tt_latch_tester_pkg.sv
// Shared types and constants for the D-latch tester.
//   state_t      : tester FSM states
//   LFSR_TAPS    : Fibonacci tap mask for x^8+x^6+x^5+x^4+1 (left shift, feedback into bit 0)
//   ERR_MAX      : saturation value of the 4-bit error counter
//   lfsr_feedback/lfsr_next : one LFSR step
//   sat_inc      : saturating error-counter increment
package tt_latch_tester_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        CHK_T,
        CLOSE,
        FLIP,
        CHK_H,
        DONE
    } state_t;

    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [3:0] ERR_MAX   = 4'hF;

    function automatic logic lfsr_feedback(input logic [7:0] cur);
        return ^(cur & LFSR_TAPS);
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], lfsr_feedback(cur)};
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == ERR_MAX) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/latch_tester_lfsr8.sv
// 8-bit Fibonacci LFSR used to pick the D value of each test vector.
//   clk, rst_n : clock, asynchronous active-low reset (clears to zero)
//   load, seed : load seed (priority over step)
//   step       : advance one position
//   q          : current LFSR state
// The zero reset value is never used for stimulus: every run loads the seed first.
module latch_tester_lfsr8
    import tt_latch_tester_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       step,
    output logic [7:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= seed;
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/tt_um_islam_ihfaz_latch_tester.sv
// Tiny Tapeout tile that exercises an external level-sensitive D latch.
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : unused
//   ui_in      : [0] start (rising edge), [1] abort (level), [7:4] run length code K
//   uo_out     : [0] busy, [1] done, [2] pass, [3] fail, [7:4] saturating error count
//   uio_in     : [2] Q from the latch under test
//   uio_out    : [0] D drive, [1] E drive, rest 0
//   uio_oe     : constant 8'h03
// Each vector: DRIVE (E=1, D=b) -> CHK_T (Q==b?) -> CLOSE (E=0) -> FLIP (D=~b)
// -> CHK_H (Q still b?). A run has 16*(K+1) vectors; all outputs are registered.
module tt_um_islam_ihfaz_latch_tester
    import tt_latch_tester_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned CW     = $clog2(SETTLE_CYCLES);
    localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES - 1);

    // Synchronisers
    logic start_s1, start_s2, start_prev;
    logic abort_s1, abort_s2;
    logic q_s1, q_s2;

    // FSM state and registered outputs
    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [3:0]    k_reg;
    logic [8:0]    vec;
    logic [3:0]    errcnt;
    logic          d_drv, e_drv;
    logic          busy, done, pass, fail;

    // LFSR interface
    logic       lfsr_load, lfsr_step;
    logic [7:0] lfsr_q;

    // Derived combinational helpers (internal only)
    logic       start_pulse;
    logic       next_bit;
    logic       t_err, h_err;
    logic [3:0] errcnt_h;
    logic [8:0] vec_next, vec_target;
    logic       unused_inputs;

    assign unused_inputs = &{1'b0, ena, ui_in[3:2], uio_in[7:3], uio_in[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_s1   <= 1'b0;
            start_s2   <= 1'b0;
            start_prev <= 1'b0;
            abort_s1   <= 1'b0;
            abort_s2   <= 1'b0;
            q_s1       <= 1'b0;
            q_s2       <= 1'b0;
        end else begin
            start_s1   <= ui_in[0];
            start_s2   <= start_s1;
            start_prev <= start_s2;
            abort_s1   <= ui_in[1];
            abort_s2   <= abort_s1;
            q_s1       <= uio_in[2];
            q_s2       <= q_s1;
        end
    end

    always_comb begin
        start_pulse = start_s2 & ~start_prev;
        next_bit    = lfsr_feedback(lfsr_q);
        t_err       = (q_s2 != d_drv);
        h_err       = (q_s2 != lfsr_q[0]);
        errcnt_h    = h_err ? sat_inc(errcnt) : errcnt;
        vec_next    = vec + 9'd1;
        vec_target  = {1'b0, k_reg, 4'b0000} + 9'd16;
    end

    // LFSR control mirrors the FSM transitions below; abort suppresses both.
    always_comb begin
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        if (!abort_s2) begin
            case (state)
                IDLE, DONE: lfsr_load = start_pulse;
                CHK_H:      lfsr_step = 1'b1;
                default:    ;
            endcase
        end
    end

    latch_tester_lfsr8 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .seed  (LFSR_SEED),
        .step  (lfsr_step),
        .q     (lfsr_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
            k_reg    <= '0;
            vec      <= '0;
            errcnt   <= '0;
            d_drv    <= 1'b0;
            e_drv    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            fail     <= 1'b0;
        end else if (abort_s2) begin
            // Abort cancels a run but keeps errcnt; in IDLE/DONE it only masks start.
            if (state != IDLE && state != DONE) begin
                state <= IDLE;
                d_drv <= 1'b0;
                e_drv <= 1'b0;
                busy  <= 1'b0;
                done  <= 1'b0;
                pass  <= 1'b0;
                fail  <= 1'b0;
            end
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_pulse) begin
                        k_reg    <= ui_in[7:4];
                        errcnt   <= '0;
                        vec      <= '0;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                        fail     <= 1'b0;
                        busy     <= 1'b1;
                        e_drv    <= 1'b1;
                        d_drv    <= LFSR_SEED[0];
                        wait_cnt <= RELOAD;
                        state    <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (wait_cnt == '0) state <= CHK_T;
                    else                wait_cnt <= wait_cnt - CW'(1);
                end
                CHK_T: begin
                    if (t_err) errcnt <= sat_inc(errcnt);
                    e_drv    <= 1'b0;
                    wait_cnt <= RELOAD;
                    state    <= CLOSE;
                end
                CLOSE: begin
                    if (wait_cnt == '0) begin
                        d_drv    <= ~lfsr_q[0];
                        wait_cnt <= RELOAD;
                        state    <= FLIP;
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                FLIP: begin
                    if (wait_cnt == '0) state <= CHK_H;
                    else                wait_cnt <= wait_cnt - CW'(1);
                end
                CHK_H: begin
                    errcnt <= errcnt_h;
                    vec    <= vec_next;
                    if (vec_next == vec_target) begin
                        d_drv <= 1'b0;
                        e_drv <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (errcnt_h == '0);
                        fail  <= (errcnt_h != '0);
                        state <= DONE;
                    end else begin
                        // The LFSR steps on this same edge, so drive its next bit 0.
                        d_drv    <= next_bit;
                        e_drv    <= 1'b1;
                        wait_cnt <= RELOAD;
                        state    <= DRIVE;
                    end
                end
                default: begin
                    d_drv <= 1'b0;
                    e_drv <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign uo_out  = {errcnt, fail, pass, done, busy};
    assign uio_out = {6'b000000, e_drv, d_drv};
    assign uio_oe  = 8'h03;

endmodule

// File: tb/tb_tt_um_islam_ihfaz_latch_tester.sv
module tb_tt_um_islam_ihfaz_latch_tester;

    localparam int unsigned S = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort;
    logic [3:0] kcode;
    int         mode;          // 0 ideal latch, 1 Q stuck 0, 2 transparent-only
    logic       latch_q;
    logic       q_model;
    logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;

    typedef struct {
        int unsigned busy_cycles;
        int unsigned vectors;
        int unsigned errs;
        logic        pass;
        logic        fail;
    } exp_t;

    exp_t sb[$];
    logic d_exp[$];

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    assign ui_in = {kcode, 2'b00, abort, start};

    always_latch begin
        if (uio_out[1]) latch_q <= uio_out[0];
    end

    always_comb begin
        q_model = latch_q;
        case (mode)
            1:       q_model = 1'b0;
            2:       q_model = uio_out[0];
            default: q_model = latch_q;
        endcase
    end

    assign uio_in = {5'b00000, q_model, 2'b00};

    tt_um_islam_ihfaz_latch_tester #(
        .SETTLE_CYCLES (S),
        .LFSR_SEED     (8'hA5)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (1'b1),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: independent LFSR walk producing the D sequence and final result.
    task automatic push_model(input int m, input logic [3:0] k);
        logic [7:0]  q;
        logic        b;
        int unsigned n;
        int unsigned errs;
        exp_t        e;
        q    = 8'hA5;
        n    = 16 * (int'(k) + 1);
        errs = 0;
        for (int unsigned i = 0; i < n; i++) begin
            b = q[0];
            d_exp.push_back(b);
            if (m == 1 && b) errs += 2;
            if (m == 2)      errs += 1;
            q = {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        end
        e.busy_cycles = n * (3 * S + 2);
        e.vectors     = n;
        e.errs        = (errs > 15) ? 15 : errs;
        e.pass        = (errs == 0);
        e.fail        = (errs != 0);
        sb.push_back(e);
    endtask

    // Start a run, optionally re-pulse start and change K mid-run, wait for done.
    task automatic do_run(input int m, input logic [3:0] k,
                          input int unsigned inject_at, input logic [3:0] k_mid);
        int unsigned busy_cyc;
        int unsigned vecs;
        bit          seen_busy;
        bit          timed_out;
        logic        prev_e;
        logic        b;
        exp_t        e;
        mode  = m;
        kcode = k;
        push_model(m, k);
        start     = 1'b1;
        busy_cyc  = 0;
        vecs      = 0;
        seen_busy = 1'b0;
        timed_out = 1'b1;
        prev_e    = uio_out[1];
        for (int unsigned c = 1; c <= 6000; c++) begin
            @(negedge clk);
            if (c == 3) start = 1'b0;
            if (inject_at != 0 && c == inject_at) begin
                start = 1'b1;
                kcode = k_mid;
            end
            if (inject_at != 0 && c == inject_at + 4) start = 1'b0;
            if (uo_out[0]) begin
                busy_cyc++;
                seen_busy = 1'b1;
            end
            if (uio_out[1] && !prev_e) begin
                vecs++;
                if (d_exp.size() != 0) begin
                    b = d_exp.pop_front();
                    chk("d_drive", uio_out[0], b);
                end
            end
            prev_e = uio_out[1];
            if (seen_busy && uo_out[1]) begin
                timed_out = 1'b0;
                break;
            end
        end
        chk("run_timeout", timed_out, 0);
        e = sb.pop_front();
        chk("busy_cycles", busy_cyc, e.busy_cycles);
        chk("vectors", vecs, e.vectors);
        chk("errcnt", uo_out[7:4], e.errs);
        chk("pass", uo_out[2], e.pass);
        chk("fail", uo_out[3], e.fail);
        chk("busy_at_done", uo_out[0], 0);
        chk("uio_at_done", uio_out, 0);
        chk("d_left", d_exp.size(), 0);
        d_exp.delete();
    endtask

    initial begin
        int unsigned vecs;
        bit          hit;
        logic        prev_e;

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        kcode = 4'd0;
        mode  = 0;
        repeat (3) @(negedge clk);
        chk("rst_uo_out", uo_out, 0);
        chk("rst_uio_out", uio_out, 0);
        chk("rst_uio_oe", uio_oe, 8'h03);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_uo_out", uo_out, 0);

        // Ideal latch, then stuck-at-0, then transparent-only, each K=0.
        do_run(0, 4'd0, 0, 4'd0);
        do_run(1, 4'd0, 0, 4'd0);
        do_run(2, 4'd0, 0, 4'd0);

        // Abort during vector 5 of a transparent-only run (4 errors so far).
        mode  = 2;
        kcode = 4'd0;
        start = 1'b1;
        vecs  = 0;
        hit   = 1'b0;
        prev_e = uio_out[1];
        for (int unsigned c = 1; c <= 1000; c++) begin
            @(negedge clk);
            if (c == 3) start = 1'b0;
            if (uio_out[1] && !prev_e) vecs++;
            prev_e = uio_out[1];
            if (vecs == 5) begin
                hit = 1'b1;
                break;
            end
        end
        start = 1'b0;
        chk("abort_reach_v5", hit, 1);
        abort = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_flags", uo_out[3:0], 0);
        chk("abort_uio", uio_out, 0);
        chk("abort_errcnt", uo_out[7:4], 4);

        // Start together with abort is masked, also after abort releases.
        start = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_blocks_start", uo_out[0], 0);
        start = 1'b0;
        repeat (4) @(negedge clk);
        abort = 1'b0;
        repeat (6) @(negedge clk);
        chk("no_start_after_abort", uo_out[0], 0);
        chk("errcnt_held", uo_out[7:4], 4);
        do_run(0, 4'd0, 0, 4'd0);

        // K=15 with a mid-run start pulse and K change: still 256 vectors.
        do_run(0, 4'd15, 500, 4'd0);

        // Asynchronous reset while in FLIP of vector 2.
        mode  = 0;
        kcode = 4'd0;
        start = 1'b1;
        vecs  = 0;
        hit   = 1'b0;
        prev_e = uio_out[1];
        for (int unsigned c = 1; c <= 1000; c++) begin
            @(negedge clk);
            if (c == 3) start = 1'b0;
            if (uio_out[1] && !prev_e) vecs++;
            if (vecs == 2 && prev_e && !uio_out[1]) begin
                hit = 1'b1;
                prev_e = uio_out[1];
                break;
            end
            prev_e = uio_out[1];
        end
        start = 1'b0;
        chk("reach_close", hit, 1);
        repeat (5) @(negedge clk);
        chk("flip_busy", uo_out[0], 1);
        chk("flip_e_low", uio_out[1], 0);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_uo", uo_out, 0);
        chk("async_rst_uio", uio_out, 0);
        chk("async_rst_oe", uio_oe, 8'h03);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_rst_idle", uo_out, 0);
        do_run(0, 4'd0, 0, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
